// File: rtl/mem_arb_pkg.sv
// Shared owner encoding and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int DEFAULT_SIZE       = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_MAX_WAIT   = 4;
  localparam int WAIT_CNT_W         = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_wait_counter.sv
// Saturating count of consecutive fetch denials; sat_o flags that fetch must win next.
module mem_arb_wait_counter
  import mem_arb_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  inc_i,
  input  logic                  clr_i,
  input  logic [WAIT_CNT_W-1:0] limit_i,
  output logic                  sat_o
);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < limit_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == limit_i);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between an instruction-fetch port and a load/store port.
// Data wins by default; a fetch denied MAX_WAIT times in a row is forced through.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int SIZE       = DEFAULT_SIZE,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [SIZE-1:0]       if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [SIZE-1:0]       d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [SIZE-1:0]       d_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [SIZE-1:0]       m_wdata,
  input  logic [SIZE-1:0]       m_rdata
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

  owner_e          owner_q;
  owner_e          owner_d;
  logic [SIZE-1:0] if_rdata_q;
  logic [SIZE-1:0] d_rdata_q;
  logic            if_starved;

  mem_arb_wait_counter u_wait (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc_i   (if_req & ~if_gnt),
    .clr_i   (if_gnt | ~if_req),
    .limit_i (WAIT_LIMIT),
    .sat_o   (if_starved)
  );

  // Grants are gated by RESET_N so nothing reaches the RAM while in reset.
  assign if_gnt  = RESET_N & if_req & (~d_req | if_starved);
  assign d_gnt   = RESET_N & d_req & ~if_gnt;

  assign m_en    = if_gnt | d_gnt;
  assign m_we    = d_gnt & d_we;
  assign m_addr  = if_gnt ? if_addr : d_addr;
  assign m_wdata = d_gnt ? d_wdata : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      owner_q    <= OWN_NONE;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == OWN_IF) if_rdata_q <= m_rdata;
      if (owner_q == OWN_D)  d_rdata_q  <= m_rdata;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
  end

  // RAM data is forwarded straight through in the return cycle; otherwise the last value is held.
  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    case (owner_q)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = m_rdata;
      end
      OWN_D: begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end
      default: ;
    endcase
  end

endmodule
